// File: rtl/pcm_mm_pkg.sv
// Shared types and defaults for the PCM memory port slave.
package pcm_mm_pkg;

    localparam int DEFAULT_ADDR_W = 11;
    localparam int DEFAULT_DATA_W = 16;

    typedef logic [DEFAULT_ADDR_W-1:0]   pcm_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0]   pcm_data_t;
    typedef logic [DEFAULT_DATA_W/8-1:0] pcm_be_t;

    // INIT zero-fills the store after reset, RUN serves the bus until the next reset
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } pcm_resp_state_t;

endpackage

// File: rtl/pcm_mem_array.sv
// Single-port word store with byte-lane write enables and a clock enable.
// Contents are never reset; the responder zero-fills them with an init sweep.
module pcm_mem_array #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                en,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);

    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // One access per enabled cycle: a write updates only the enabled lanes, a read registers the word
    always_ff @(posedge clk) begin
        if (en) begin
            if (wr) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/pcm_mem_responder.sv
// Avalon-MM slave for the PCM memory port: zero-fill sweep after reset,
// clken-gated fixed-latency reads, byte-lane writes and per-page wear tracking.
module pcm_mem_responder
    import pcm_mm_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int READ_LATENCY = 1,
    parameter int PAGE_BITS    = 4,
    parameter int WEAR_W       = 16,
    parameter int WEAR_LIMIT   = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    s_address,
    input  logic                 s_chipselect,
    input  logic                 s_clken,
    input  logic                 s_write,
    input  logic [DATA_W-1:0]    s_writedata,
    input  logic [DATA_W/8-1:0]  s_byteenable,
    output logic [DATA_W-1:0]    s_readdata,
    output logic                 init_done,
    output logic                 wear_alarm,
    output logic [PAGE_BITS-1:0] wear_page,
    output logic [31:0]          total_writes
);

    localparam logic [WEAR_W-1:0] WEAR_LIMIT_V = WEAR_W'(WEAR_LIMIT);
    localparam logic [WEAR_W-1:0] WEAR_ONE     = WEAR_W'(1);

    pcm_resp_state_t state_q, state_d;
    logic [ADDR_W-1:0] init_ptr;

    logic                mem_en;
    logic                mem_wr;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0]   ram_q;

    logic                rd_accept;
    logic                wr_effective;
    logic                rd_vld;
    logic                retire_valid;
    logic [DATA_W-1:0]   retire_data;
    logic                pipe_step;

    logic [WEAR_W-1:0]    wear_cnt [2**PAGE_BITS];
    logic [PAGE_BITS-1:0] page_idx;
    logic [WEAR_W-1:0]    wear_next;

    // State register; reset always restarts a full zero-fill sweep
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory port steering: the sweep owns the port in INIT, the bus owns it in RUN
    always_comb begin
        state_d      = state_q;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = s_address;
        mem_wdata    = s_writedata;
        mem_be       = s_byteenable;
        rd_accept    = 1'b0;
        wr_effective = 1'b0;
        case (state_q)
            INIT: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = init_ptr;
                mem_wdata = '0;
                mem_be    = '1;
                if (init_ptr == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (s_chipselect && s_clken) begin
                    mem_en       = 1'b1;
                    mem_wr       = s_write;
                    rd_accept    = !s_write;
                    wr_effective = s_write && (|s_byteenable);
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Sweep pointer walks every word once, ignoring clken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_ptr <= '0;
        end else if (state_q == INIT) begin
            init_ptr <= init_ptr + ADDR_W'(1);
        end
    end

    assign init_done = (state_q == RUN);
    assign pipe_step = s_clken && (state_q == RUN);

    pcm_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .wr    (mem_wr),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .be    (mem_be),
        .rdata (ram_q)
    );

    // First read stage: the RAM output register pairs with this valid bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld <= 1'b0;
        end else if (pipe_step) begin
            rd_vld <= rd_accept;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              vld2;
            logic [DATA_W-1:0] data2;

            // Extra stage for the two-cycle latency option; frozen while clken is low
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld2  <= 1'b0;
                    data2 <= '0;
                end else if (pipe_step) begin
                    vld2  <= rd_vld;
                    data2 <= ram_q;
                end
            end

            assign retire_valid = vld2;
            assign retire_data  = data2;
        end else begin : g_lat1
            assign retire_valid = rd_vld;
            assign retire_data  = ram_q;
        end
    endgenerate

    // Read data only changes when a valid entry retires, so it holds across idle and stalled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_readdata <= '0;
        end else if (pipe_step && retire_valid) begin
            s_readdata <= retire_data;
        end
    end

    assign page_idx  = s_address[ADDR_W-1 -: PAGE_BITS];
    assign wear_next = (wear_cnt[page_idx] == '1) ? wear_cnt[page_idx]
                                                  : wear_cnt[page_idx] + WEAR_ONE;

    // Per-page wear counters with a sticky alarm that remembers only the first page to hit the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2**PAGE_BITS; p++) begin
                wear_cnt[p] <= '0;
            end
            wear_alarm <= 1'b0;
            wear_page  <= '0;
        end else if (wr_effective) begin
            wear_cnt[page_idx] <= wear_next;
            if ((wear_next == WEAR_LIMIT_V) && !wear_alarm) begin
                wear_alarm <= 1'b1;
                wear_page  <= page_idx;
            end
        end
    end

    // Saturating count of writes that actually touched at least one byte lane
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_writes <= '0;
        end else if (wr_effective && (total_writes != 32'hFFFF_FFFF)) begin
            total_writes <= total_writes + 32'd1;
        end
    end

endmodule

// File: tb/tb_pcm_mem_responder.sv
// Self-checking bench for pcm_mem_responder: scoreboard for read data plus direct status checks.
module tb_pcm_mem_responder;

    logic        clk;
    logic        reset;
    logic [10:0] s_address;
    logic        s_chipselect;
    logic        s_clken;
    logic        s_write;
    logic [15:0] s_writedata;
    logic [1:0]  s_byteenable;
    logic [15:0] s_readdata;
    logic        init_done;
    logic        wear_alarm;
    logic [3:0]  wear_page;
    logic [31:0] total_writes;

    int          n_checks;
    int          n_pass;
    logic [15:0] exp_q [$];
    bit          pend;
    bit          acc;
    bit          ret;
    logic [15:0] exp_val;

    pcm_mem_responder #(
        .ADDR_W       (11),
        .DATA_W       (16),
        .READ_LATENCY (1),
        .PAGE_BITS    (4),
        .WEAR_W       (16),
        .WEAR_LIMIT   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_clken      (s_clken),
        .s_write      (s_write),
        .s_writedata  (s_writedata),
        .s_byteenable (s_byteenable),
        .s_readdata   (s_readdata),
        .init_done    (init_done),
        .wear_alarm   (wear_alarm),
        .wear_page    (wear_page),
        .total_writes (total_writes)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic wr, input logic [10:0] addr,
                                 input logic [15:0] data, input logic [1:0] be, input logic ce);
        @(negedge clk);
        s_chipselect = cs;
        s_write      = wr;
        s_address    = addr;
        s_writedata  = data;
        s_byteenable = be;
        s_clken      = ce;
    endtask

    task automatic doWrite(input logic [10:0] addr, input logic [15:0] data, input logic [1:0] be);
        applyStimulus(1'b1, 1'b1, addr, data, be, 1'b1);
    endtask

    task automatic doRead(input logic [10:0] addr, input logic [15:0] expected);
        exp_q.push_back(expected);
        applyStimulus(1'b1, 1'b0, addr, 16'h0000, 2'b00, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b1);
        end
    endtask

    // Counts edges from reset release until init_done; bounded so a stuck sweep still ends the run
    task automatic waitInit(input string name);
        int cnt;
        cnt = 0;
        while (!init_done && cnt < 3000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput(name, cnt, 2048);
    endtask

    // Monitor: tracks accepted reads from the bus and compares each retiring read against the scoreboard
    always @(posedge clk) begin
        if (reset) begin
            pend = 1'b0;
        end else if (s_clken) begin
            acc  = s_chipselect && !s_write && init_done;
            ret  = pend;
            pend = acc;
            if (ret) begin
                #1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL read_underflow: got 0x%0h, expected no read", s_readdata);
                end else begin
                    exp_val = exp_q.pop_front();
                    checkOutput("readdata", {16'h0, s_readdata}, {16'h0, exp_val});
                end
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Directed stimulus sequence
    initial begin
        n_checks     = 0;
        n_pass       = 0;
        pend         = 1'b0;
        reset        = 1'b1;
        s_chipselect = 1'b0;
        s_write      = 1'b0;
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        s_clken      = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_readdata", {16'h0, s_readdata}, 32'h0);
        checkOutput("rst_init_done", {31'h0, init_done}, 32'h0);
        checkOutput("rst_wear_alarm", {31'h0, wear_alarm}, 32'h0);
        checkOutput("rst_wear_page", {28'h0, wear_page}, 32'h0);
        checkOutput("rst_total_writes", total_writes, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        waitInit("init_cycles");

        doRead(11'h7FF, 16'h0000);
        idle(2);

        doWrite(11'h123, 16'hBEEF, 2'b11);
        doRead(11'h123, 16'hBEEF);
        idle(2);

        doRead(11'h7FF, 16'h0000);
        doRead(11'h123, 16'hBEEF);
        applyStimulus(1'b0, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b0);
        checkOutput("stall_hold0", {16'h0, s_readdata}, 32'h0);
        applyStimulus(1'b0, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b0);
        checkOutput("stall_hold1", {16'h0, s_readdata}, 32'h0);
        applyStimulus(1'b0, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b0);
        checkOutput("stall_hold2", {16'h0, s_readdata}, 32'h0);
        idle(1);
        checkOutput("stall_hold3", {16'h0, s_readdata}, 32'h0);
        idle(2);

        doWrite(11'h123, 16'h1234, 2'b01);
        doRead(11'h123, 16'hBE34);
        idle(2);

        for (int i = 0; i < 3; i++) doWrite(11'h080, 16'h1111, 2'b11);
        idle(1);
        checkOutput("wear_before_limit", {31'h0, wear_alarm}, 32'h0);
        doWrite(11'h080, 16'h2222, 2'b11);
        idle(1);
        checkOutput("wear_alarm_set", {31'h0, wear_alarm}, 32'h1);
        checkOutput("wear_page_first", {28'h0, wear_page}, 32'h1);

        for (int i = 0; i < 4; i++) doWrite(11'h100, 16'h3333, 2'b11);
        idle(1);
        checkOutput("wear_alarm_sticky", {31'h0, wear_alarm}, 32'h1);
        checkOutput("wear_page_kept", {28'h0, wear_page}, 32'h1);
        checkOutput("total_after_wear", total_writes, 32'd10);

        for (int i = 0; i < 10; i++) begin
            if (i == 5) doWrite(11'h200 + 11'(i), 16'hDEAD, 2'b00);
            else        doWrite(11'h200 + 11'(i), 16'h1000 + 16'(i), 2'b11);
        end
        idle(1);
        checkOutput("total_writes_19", total_writes, 32'd19);
        checkOutput("wear_page_page4", {28'h0, wear_page}, 32'h1);
        doRead(11'h205, 16'h0000);
        doRead(11'h209, 16'h1009);
        idle(3);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 500; i++) doWrite(11'h123, 16'hFFFF, 2'b11);
        checkOutput("init_busy", {31'h0, init_done}, 32'h0);
        checkOutput("init_ignores_writes", total_writes, 32'h0);
        checkOutput("init_readdata_zero", {16'h0, s_readdata}, 32'h0);
        @(negedge clk);
        reset        = 1'b1;
        s_chipselect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_init_done", {31'h0, init_done}, 32'h0);
        reset = 1'b0;
        waitInit("reinit_cycles");

        doRead(11'h123, 16'h0000);
        doRead(11'h204, 16'h0000);
        idle(3);
        checkOutput("reinit_total", total_writes, 32'h0);
        checkOutput("reinit_alarm", {31'h0, wear_alarm}, 32'h0);
        checkOutput("reinit_page", {28'h0, wear_page}, 32'h0);
        checkOutput("scoreboard_drained", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
